// File: rtl/cb4_chain_sched_if.sv
// cb4_chain_sched_if: request/grant, completion and readback signals of the chain scheduler
interface cb4_chain_sched_if #(parameter int NCH = 4, parameter int WIDTH = 16) ();
  localparam int CW = $clog2(NCH);
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   up;
  logic [CW-1:0]    rd_sel;
  logic [NCH-1:0]   gnt;
  logic             busy;
  logic             done;
  logic [CW-1:0]    done_ch;
  logic             wrap;
  logic [WIDTH-1:0] rd_data;
  modport master (output req, up, rd_sel, input gnt, busy, done, done_ch, wrap, rd_data);
  modport slave  (input req, up, rd_sel, output gnt, busy, done, done_ch, wrap, rd_data);
endinterface

// File: rtl/cb4_chain_sched.sv
// cb4_chain_sched: round-robin sharing of one 4-bit up/down slice across NCH counters, nibble-serial
module cb4_chain_sched #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  cb4_chain_sched_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NCH);
  localparam int KW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           st;
  logic [CW-1:0]    ptr, ch, sel;
  logic             dir, c;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] cnt [NCH];
  logic [4:0]       sum;
  logic [NCH-1:0]   gnt;
  logic             busy, done, wrap;
  logic [CW-1:0]    done_ch;
  // descending scan so the channel closest after ptr wins
  always_comb begin
    sel = ptr;
    for (int i = NCH - 1; i >= 0; i--)
      if (bus.req[(int'(ptr) + i) % NCH]) sel = CW'((int'(ptr) + i) % NCH);
    sum = {1'b0, acc[k*4 +: 4]} + {1'b0, dir ? 4'h0 : 4'hF} + {4'b0, c};
    acc_nx = acc;
    acc_nx[k*4 +: 4] = sum[3:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      ptr     <= '0;
      ch      <= '0;
      dir     <= 1'b0;
      c       <= 1'b0;
      k       <= '0;
      acc     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_ch <= '0;
      wrap    <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      case (st)
        IDLE: if (|bus.req) begin
          st   <= RUN;
          gnt  <= NCH'(1) << sel;
          busy <= 1'b1;
          ch   <= sel;
          dir  <= bus.up[sel];
          c    <= bus.up[sel];
          acc  <= cnt[sel];
          k    <= '0;
          ptr  <= (sel == CW'(NCH - 1)) ? '0 : sel + 1'b1;
        end
        RUN: begin
          gnt <= '0;
          acc <= acc_nx;
          c   <= sum[4];
          k   <= k + 1'b1;
          if (k == KW'(NIB - 1)) begin
            st      <= DONE;
            cnt[ch] <= acc_nx;
            done    <= 1'b1;
            done_ch <= ch;
            wrap    <= dir ? sum[4] : ~sum[4];
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
          wrap <= 1'b0;
        end
      endcase
    end
  end
  assign bus.gnt     = gnt;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.done_ch = done_ch;
  assign bus.wrap    = wrap;
  assign bus.rd_data = (int'(bus.rd_sel) < NCH) ? cnt[bus.rd_sel] : '0;
endmodule

// File: tb/tb_cb4_chain_sched.sv
// tb_cb4_chain_sched: directed vectors, completions checked by a scoreboard monitor
module tb_cb4_chain_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   err = 0;
  int   cyc = 0;
  logic [2:0] exp_q[$];
  cb4_chain_sched_if #(.NCH(4), .WIDTH(16)) b ();
  cb4_chain_sched #(.NCH(4), .WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && b.done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'(b.done_ch), 32'hFFFF_FFFF);
      else begin
        logic [2:0] x;
        x = exp_q.pop_front();
        chk("done_ch", 32'(b.done_ch), 32'(x[2:1]));
        chk("wrap", 32'(b.wrap), 32'(x[0]));
      end
    end
  end
  task automatic reset_dut();
    rst_n = 1'b0;
    b.req = '0;
    b.up = '0;
    b.rd_sel = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic check_counters(input logic [15:0] v0, v1, v2, v3);
    logic [15:0] ev [4];
    ev[0] = v0; ev[1] = v1; ev[2] = v2; ev[3] = v3;
    for (int i = 0; i < 4; i++) begin
      b.rd_sel = 2'(i);
      #1 chk("rd_counter", 32'(b.rd_data), 32'(ev[i]));
    end
  endtask
  task automatic op(input int ch, input bit dir, input logic [15:0] old_v, new_v, input bit w);
    b.req[ch] = 1'b1;
    b.up[ch] = dir;
    b.rd_sel = 2'(ch);
    exp_q.push_back({2'(ch), w});
    @(negedge clk);
    chk("gnt", 32'(b.gnt), 32'(1) << ch);
    chk("busy", 32'(b.busy), 1);
    chk("rd_old", 32'(b.rd_data), 32'(old_v));
    b.req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("no_early_done", 32'(b.done), 0);
      chk("rd_hold", 32'(b.rd_data), 32'(old_v));
    end
    @(negedge clk);
    chk("done", 32'(b.done), 1);
    chk("rd_new", 32'(b.rd_data), 32'(new_v));
    @(negedge clk);
    chk("idle", 32'(b.busy), 0);
  endtask
  initial begin
    int last;
    reset_dut();
    @(negedge clk);
    chk("rst_gnt", 32'(b.gnt), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_done", 32'(b.done), 0);
    chk("rst_done_ch", 32'(b.done_ch), 0);
    chk("rst_wrap", 32'(b.wrap), 0);
    check_counters(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) begin
      @(negedge clk);
      chk("no_gnt_idle", 32'(b.gnt), 0);
    end
    op(0, 1'b1, 16'h0000, 16'h0001, 1'b0);
    op(2, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
    op(2, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    check_counters(16'h1, 16'h0, 16'h0, 16'h0);
    reset_dut();
    @(negedge clk);
    b.req = 4'hF;
    b.up = 4'hF;
    for (int n = 0; n < 5; n++) exp_q.push_back({2'(n % 4), 1'b0});
    last = 0;
    for (int n = 0; n < 5; n++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (b.gnt == 0 && t < 12) begin
        @(negedge clk);
        t++;
      end
      chk("rr_gnt", 32'(b.gnt), 32'(1) << (n % 4));
      if (n > 0) chk("rr_spacing", 32'(cyc - last), 6);
      last = cyc;
      if (n == 4) b.req = '0;
    end
    repeat (6) @(negedge clk);
    check_counters(16'h2, 16'h1, 16'h1, 16'h1);
    for (int i = 1; i < 15; i++) op(1, 1'b1, 16'(i), 16'(i + 1), 1'b0);
    op(1, 1'b1, 16'h000F, 16'h0010, 1'b0);
    b.req[1] = 1'b1;
    b.up[1] = 1'b1;
    @(negedge clk);
    chk("abort_gnt", 32'(b.gnt), 32'h2);
    b.req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", 32'(b.done), 0);
    end
    check_counters(16'h0, 16'h0, 16'h0, 16'h0);
    b.req[3] = 1'b1;
    b.up[3] = 1'b1;
    op(1, 1'b1, 16'h0000, 16'h0001, 1'b0);
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
